pixel_reader: RTL

Upstream feeder for the BRAM write stage. On start, fetches packed 32-bit words from the input-image BRAM, unpacks them into a one-pixel-per-cycle stream with valid/ready handshake, and pulses done after the last pixel is accepted. Sits between the PS-loaded input BRAM and the convolution/write path. Its done output drives the downstream conv_done.

---
 rtl/fl_comm_pkg.sv | 13 +
 rtl/pixel_reader_word_unpacker.sv | 63 ++++++
 rtl/pixel_reader.sv | 117 +++++++++++
 3 files changed

// File: rtl/fl_comm_pkg.sv
// Shared widths and reader FSM encoding for the frame-load path.
package fl_comm_pkg;
  localparam int DATA_WIDTH      = 32;
  localparam int ADDR_WIDTH      = 32;
  localparam int PIXEL_SIZE      = 8;
  localparam int PIXELS_PER_WORD = DATA_WIDTH / PIXEL_SIZE;

  // pixel_reader states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
endpackage

// File: rtl/pixel_reader_word_unpacker.sv
// Two-entry word FIFO that presents the head word one pixel at a time,
// little-endian (lowest byte first), with a valid/ready output.
module word_unpacker
  import fl_comm_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  last_pix,
  input  logic                  pixel_ready,
  output logic [1:0]            buf_cnt,
  output logic                  pop,
  output logic                  xfer,
  output logic [PIXEL_SIZE-1:0] pixel,
  output logic                  pixel_valid
);
  localparam int IW = (PIXELS_PER_WORD > 1) ? $clog2(PIXELS_PER_WORD) : 1;

  logic [DATA_WIDTH-1:0] word_buf [2];
  logic                  wr_ptr, rd_ptr;
  logic [IW-1:0]         idx;
  logic [1:0]            cnt;
  logic                  flush;

  assign buf_cnt     = cnt;
  assign pixel_valid = (cnt != 2'd0);
  assign pixel       = word_buf[rd_ptr][int'(idx)*PIXEL_SIZE +: PIXEL_SIZE];
  assign xfer        = pixel_valid && pixel_ready;
  // Head word retires after its top byte, or early on the frame's last pixel
  // so trailing bytes of a partial word are never shown.
  assign pop         = xfer && (last_pix || idx == IW'(PIXELS_PER_WORD - 1));
  assign flush       = xfer && last_pix;

  // FIFO pointers, occupancy and byte index
  always_ff @(posedge clk) begin
    if (!reset) begin
      word_buf[0] <= '0;
      word_buf[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      idx         <= '0;
      cnt         <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      idx    <= '0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        word_buf[wr_ptr] <= push_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        idx    <= '0;
      end else if (xfer) begin
        idx <= idx + IW'(1);
      end
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/pixel_reader.sv
// Frame reader: issues BRAM word reads, tracks read latency, and streams
// unpacked pixels one per cycle; pulses done after the last pixel.
module pixel_reader
  import fl_comm_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] INPUT_ADDR   = 32'h4000_0000,
  parameter int                    NUM_PIXELS   = 784,
  parameter int                    READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  input  logic [DATA_WIDTH-1:0] bram_data,
  output logic [PIXEL_SIZE-1:0] pixel,
  output logic                  pixel_valid,
  input  logic                  pixel_ready,
  output logic                  done
);
  localparam int NUM_WORDS = (NUM_PIXELS * PIXEL_SIZE + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int WC_W      = $clog2(NUM_WORDS + 1);
  localparam int PC_W      = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

  logic [1:0]            state, state_nxt;
  logic [WC_W-1:0]       words_issued;
  logic [ADDR_WIDTH-1:0] next_addr, rd_addr;
  logic [READ_LATENCY:1] vld_pipe;
  logic [PC_W-1:0]       pix_cnt;
  logic [1:0]            buf_cnt;
  logic [2:0]            in_flight;
  logic                  pop, xfer, last_pix, issue, frame_end;

  assign last_pix  = (pix_cnt == PC_W'(NUM_PIXELS - 1));
  assign frame_end = xfer && last_pix;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign rd_addr   = (state == ST_IDLE) ? INPUT_ADDR : next_addr;

  // Reads issued but not yet captured (strobe this cycle plus latency pipe)
  always_comb begin
    in_flight = {2'b00, bram_en};
    for (int k = 1; k <= READ_LATENCY; k++)
      in_flight = in_flight + {2'b00, vld_pipe[k]};
  end

  // Issue while buffered+in-flight stays under two; a word retiring this
  // cycle already frees its slot, which keeps latency 3 bubble-free.
  always_comb begin
    issue = 1'b0;
    if (state == ST_IDLE)
      issue = start;
    else if (state == ST_RUN)
      issue = (words_issued != WC_W'(NUM_WORDS)) &&
              (({1'b0, buf_cnt} + in_flight - {2'b00, pop}) < 3'd2);
  end

  // Frame sequencing
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN:   if (frame_end) state_nxt = ST_DONE;
                else if (words_issued == WC_W'(NUM_WORDS)) state_nxt = ST_FLUSH;
      ST_FLUSH: if (frame_end) state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State, read strobe/address generation and pixel counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      bram_en      <= 1'b0;
      bram_addr    <= INPUT_ADDR;
      next_addr    <= INPUT_ADDR;
      words_issued <= '0;
      pix_cnt      <= '0;
    end else begin
      state   <= state_nxt;
      bram_en <= issue;
      if (issue) begin
        bram_addr    <= rd_addr;
        next_addr    <= rd_addr + ADDR_WIDTH'(4);
        words_issued <= (state == ST_IDLE) ? WC_W'(1) : words_issued + WC_W'(1);
      end
      if (xfer)
        pix_cnt <= last_pix ? '0 : pix_cnt + PC_W'(1);
    end
  end

  // Read-latency valid pipe; the top bit marks bram_data as capturable
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= bram_en;
      for (int k = 2; k <= READ_LATENCY; k++)
        vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  word_unpacker u_unpack (
    .clk         (clk),
    .reset       (reset),
    .push        (vld_pipe[READ_LATENCY]),
    .push_data   (bram_data),
    .last_pix    (last_pix),
    .pixel_ready (pixel_ready),
    .buf_cnt     (buf_cnt),
    .pop         (pop),
    .xfer        (xfer),
    .pixel       (pixel),
    .pixel_valid (pixel_valid)
  );
endmodule
